msu_result_collector: RTL and testbench
=======================================

Name: msu_result_collector

Overview:
- Downstream neighbour of the MSU squaring unit: consumes the MSU outgoing AXI-stream and reassembles it into one wide result (t_current, sq_out) for the host-side control logic.
- The MSU never asserts tlast, so this block frames each transfer by word count. It arms on the MSU start_xfer pulse and holds the assembled result under a valid/ready handshake.

Parameters:
- AXI_LEN, 32, stream data width in bits.
- C_XFER_SIZE_WIDTH, 32, width of the transfer-size field.
- T_LEN, 64, iteration-counter width.
- SQ_OUT_BITS, 1024, squarer result width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_xfer  in  1  MSU pulse marking an upcoming result transfer.
- s_axis_tvalid  in  1  incoming stream valid.
- s_axis_tready  out  1  incoming stream ready.
- s_axis_tdata  in  AXI_LEN  stream data; first word is least significant.
- s_axis_tkeep  in  AXI_LEN/8  byte enables; all ones is required.
- s_axis_tlast  in  1  optional early framing.
- s_axis_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  size advertised by the MSU.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts the result.
- res_t  out  T_LEN  collected t_current.
- res_sq  out  SQ_OUT_BITS  collected sq_out.
- err_flags  out  4  sticky errors: [0] size mismatch, [1] bad tkeep, [2] early tlast, [3] overrun/monotonic.
- err_clr  in  1  clears err_flags.

Behaviour:
- Constants:
  - IN_WORDS = T_LEN/AXI_LEN + SQ_OUT_BITS/AXI_LEN (34 by default).
  - EXP_BYTES = IN_WORDS*AXI_LEN/8 (136 by default).
- Reset (reset_n low, asynchronous): state IDLE; s_axis_tready=0; res_valid=0; res_t=0; res_sq=0; err_flags=0; word counter=0.
- State IDLE:
  - s_axis_tready=0.
  - On start_xfer: go to COLLECT, clear the counter, and sample s_axis_xfer_size_in_bytes.
  - If the sampled size != EXP_BYTES, set err[0]; collection proceeds regardless.
- State COLLECT:
  - s_axis_tready=1.
  - Each tvalid&&tready beat shifts tdata into the MSB of the assembly register (right shift by AXI_LEN) and increments the counter.
  - tkeep != all ones on any beat sets err[1]; the data is still accepted.
  - A beat with counter == IN_WORDS-1 finishes the transfer: next cycle is HOLD with res_valid=1.
  - res_t = assembly[T_LEN-1:0]; res_sq = assembly[top:T_LEN].
  - tlast on a beat before the last: set err[2], go to HOLD; unfilled words read as 0 (right-aligned by shifting in the remaining positions with zeros over the following cycles, tready=0 meanwhile).
  - tlast on the final beat is legal.
- State HOLD:
  - res_valid=1; outputs stable.
  - res_valid&&res_ready: clear res_valid next cycle, go to IDLE.
  - start_xfer seen in HOLD sets err[3]; the pulse is dropped and the held result is kept.
- Latency: res_valid rises 1 cycle after the accepting final beat. Throughput is 1 beat/cycle; tvalid gaps stall only the counter.
- Simultaneous events:
  - start_xfer in COLLECT: ignored, sets err[3].
  - err_clr in the same cycle as a new error: the error wins (remains set).
  - res_ready when res_valid=0: no effect.
- The counter is C_XFER_SIZE_WIDTH wide and saturates; it never wraps.
- reset_n asserted mid-COLLECT: partial data is discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: MSU_COLLECT_MONOTONIC_EN.
- When defined:
  - A register last_t (reset 0) holds the last released res_t.
  - A completed result with res_t <= last_t (and last_t != 0) sets err[3].
  - last_t updates on each valid&&ready handshake.
- When undefined: no last_t register; err[3] reflects overrun only.

Decomposition:
- Package msu_collect_pkg:
  - state enum {IDLE, COLLECT, HOLD}.
  - err bit-index localparams (ERR_SIZE=0, ERR_KEEP=1, ERR_TLAST=2, ERR_OVR=3).
  - function words_for(T_LEN, SQ_OUT_BITS, AXI_LEN).
- One natural sub-module: msu_axis_shift_acc, the parameterised right-shift word accumulator with counter and zero-fill.

Test Plan:
- Nominal transfer:
  - Stimulus: start_xfer, size=136, then 34 beats: beat0=0x0000_0005, beat1=0, beats2..33=0xA5A5_0000+i, res_ready=1.
  - Required: res_t=5; res_sq word k=0xA5A5_0000+k+2; res_valid exactly 1 cycle after beat 33; err_flags=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles after completion, pulse start_xfer at cycle 3.
  - Required: outputs stable; err[3]=1; IDLE after the handshake.
- Protocol errors:
  - Stimulus: size=128, tkeep=0x7 on beat 4, tlast on beat 20.
  - Required: err=0b0111; HOLD entered; words 21..33 of the result = 0.
- Reset:
  - Stimulus: reset_n low after beat 12, new full transfer afterwards.
  - Required: res_valid=0 immediately; the new transfer assembles correctly with no stale words.
- Stalls:
  - Stimulus: random tvalid gaps (50%) over a full transfer.
  - Required: identical result to the nominal transfer; 34 accepted beats.
- Monotonic check (MSU_COLLECT_MONOTONIC_EN defined):
  - Stimulus: two transfers with res_t=9 then 7.
  - Required: err[3]=1 after the second; err_clr returns it to 0.

Source files
------------

// File: rtl/msu_collect_pkg.sv
// Shared types and helpers for the MSU result collector.
// Holds the collector FSM states, the error-flag bit positions and the word-count helper.
package msu_collect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int ERR_W     = 4;
    localparam int ERR_SIZE  = 0;
    localparam int ERR_KEEP  = 1;
    localparam int ERR_TLAST = 2;
    localparam int ERR_OVR   = 3;

    function automatic int words_for(input int t_len, input int sq_out_bits, input int axi_len);
        return t_len / axi_len + sq_out_bits / axi_len;
    endfunction

endpackage

// File: rtl/msu_axis_shift_acc.sv
// Right-shifting word accumulator: each shifted word enters at the MSB end, so the
// first word of a transfer ends at the LSB. Zero-fill shifts right-align short transfers.
module msu_axis_shift_acc #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 34,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_beat,
    input  logic                     i_fill,
    input  logic [WORD_W-1:0]        i_data,
    output logic [WORD_W*WORDS-1:0]  o_acc,
    output logic                     o_last_slot
);

    localparam int ACC_W = WORD_W * WORDS;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_shift;
    logic [WORD_W-1:0] w_word;

    assign w_shift = i_beat | i_fill;
    assign w_word  = i_fill ? '0 : i_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            // The counter saturates at all ones rather than wrapping.
            if (i_clear)
                r_cnt <= '0;
            else if (w_shift && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            if (w_shift)
                r_acc <= {w_word, r_acc[ACC_W-1:WORD_W]};
        end
    end

    assign o_acc       = r_acc;
    assign o_last_slot = (r_cnt == CNT_W'(WORDS - 1));

endmodule

// File: rtl/msu_result_collector.sv
// Reassembles the MSU result stream (framed by word count) into {sq_out, t_current}.
// Define MSU_COLLECT_MONOTONIC_EN to flag released results whose t does not increase.
module msu_result_collector
    import msu_collect_pkg::*;
#(
    parameter int AXI_LEN           = 32,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int T_LEN             = 64,
    parameter int SQ_OUT_BITS       = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_xfer,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [AXI_LEN-1:0]           s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]         s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [T_LEN-1:0]             res_t,
    output logic [SQ_OUT_BITS-1:0]       res_sq,
    output logic [ERR_W-1:0]             err_flags,
    input  logic                         err_clr
);

    localparam int IN_WORDS  = words_for(T_LEN, SQ_OUT_BITS, AXI_LEN);
    localparam int EXP_BYTES = IN_WORDS * AXI_LEN / 8;
    localparam int ACC_W     = IN_WORDS * AXI_LEN;

    state_t           r_state, w_state_next;
    logic             r_flush, w_flush_next;
    logic [ERR_W-1:0] r_err, w_err_next;
    logic             w_beat, w_fill, w_clear, w_hs, w_last_slot;
    logic [ACC_W-1:0] w_acc;

`ifdef MSU_COLLECT_MONOTONIC_EN
    logic [T_LEN-1:0] r_last_t;
`endif

    // r_flush marks the zero-fill tail after an early tlast; input is stalled meanwhile.
    assign s_axis_tready = (r_state == COLLECT) && !r_flush;
    assign w_beat        = s_axis_tvalid && s_axis_tready;
    assign w_fill        = (r_state == COLLECT) && r_flush;
    assign w_clear       = (r_state == IDLE) && start_xfer;
    assign res_valid     = (r_state == HOLD);
    assign w_hs          = res_valid && res_ready;

    msu_axis_shift_acc #(
        .WORD_W (AXI_LEN),
        .WORDS  (IN_WORDS),
        .CNT_W  (C_XFER_SIZE_WIDTH)
    ) u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_beat      (w_beat),
        .i_fill      (w_fill),
        .i_data      (s_axis_tdata),
        .o_acc       (w_acc),
        .o_last_slot (w_last_slot)
    );

    assign res_t     = w_acc[T_LEN-1:0];
    assign res_sq    = w_acc[ACC_W-1:T_LEN];
    assign err_flags = r_err;

    always_comb begin
        w_state_next = r_state;
        w_flush_next = r_flush;
        // Clear is applied first so a same-cycle new error still lands.
        w_err_next   = err_clr ? '0 : r_err;
        case (r_state)
            IDLE: begin
                if (start_xfer) begin
                    w_state_next = COLLECT;
                    w_flush_next = 1'b0;
                    if (s_axis_xfer_size_in_bytes != C_XFER_SIZE_WIDTH'(EXP_BYTES))
                        w_err_next[ERR_SIZE] = 1'b1;
                end
            end
            COLLECT: begin
                if (start_xfer)
                    w_err_next[ERR_OVR] = 1'b1;
                if (w_beat && (s_axis_tkeep != '1))
                    w_err_next[ERR_KEEP] = 1'b1;
                if ((w_beat || w_fill) && w_last_slot) begin
                    w_state_next = HOLD;
                    w_flush_next = 1'b0;
                end else if (w_beat && s_axis_tlast) begin
                    w_err_next[ERR_TLAST] = 1'b1;
                    w_flush_next          = 1'b1;
                end
            end
            HOLD: begin
                if (start_xfer)
                    w_err_next[ERR_OVR] = 1'b1;
                if (res_ready)
                    w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_flush_next = 1'b0;
            end
        endcase
`ifdef MSU_COLLECT_MONOTONIC_EN
        if (w_hs && (r_last_t != '0) && (res_t <= r_last_t))
            w_err_next[ERR_OVR] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_next;
            r_flush <= w_flush_next;
            r_err   <= w_err_next;
        end
    end

`ifdef MSU_COLLECT_MONOTONIC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last_t <= '0;
        else if (w_hs)
            r_last_t <= res_t;
    end
`endif

endmodule

// File: tb/tb_msu_result_collector.sv
// Self-checking bench for msu_result_collector: scenario tasks compare DUT outputs
// against an expected word array describing what each transfer should assemble to.
module tb_msu_result_collector;

    localparam int NW   = 34;
    localparam int EXPB = 136;

    logic         clk;
    logic         reset_n;
    logic         start_xfer;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  s_axis_tdata;
    logic [3:0]   s_axis_tkeep;
    logic         s_axis_tlast;
    logic [31:0]  s_axis_xfer_size_in_bytes;
    logic         res_valid;
    logic         res_ready;
    logic [63:0]  res_t;
    logic [1023:0] res_sq;
    logic [3:0]   err_flags;
    logic         err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    logic [31:0] exp_w [NW];

    msu_result_collector dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .start_xfer                (start_xfer),
        .s_axis_tvalid             (s_axis_tvalid),
        .s_axis_tready             (s_axis_tready),
        .s_axis_tdata              (s_axis_tdata),
        .s_axis_tkeep              (s_axis_tkeep),
        .s_axis_tlast              (s_axis_tlast),
        .s_axis_xfer_size_in_bytes (s_axis_xfer_size_in_bytes),
        .res_valid                 (res_valid),
        .res_ready                 (res_ready),
        .res_t                     (res_t),
        .res_sq                    (res_sq),
        .err_flags                 (err_flags),
        .err_clr                   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every beat that will be accepted at the next rising edge.
    always @(negedge clk)
        if (reset_n && s_axis_tvalid && s_axis_tready)
            n_acc = n_acc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] size);
        start_xfer = 1'b1;
        s_axis_xfer_size_in_bytes = size;
        tick();
        start_xfer = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit gaps);
        if (gaps)
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = $urandom;
                tick();
            end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        for (int w = 0; w < 50 && !s_axis_tready; w++)
            tick();
        if (!s_axis_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL tready_timeout: got tready=0 required 1");
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = 4'hF;
    endtask

    task automatic fill_random(input logic [31:0] w0, input logic [31:0] w1);
        exp_w[0] = w0;
        exp_w[1] = w1;
        for (int i = 2; i < NW; i++)
            exp_w[i] = $urandom;
    endtask

    task automatic send_all(input bit gaps);
        for (int i = 0; i < NW; i++)
            send_beat(exp_w[i], 4'hF, 1'b0, gaps);
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", res_valid); end
        n_checks++; if (res_t !== 64'd0) begin n_fail++; $display("FAIL reset_res_t: got %h required 0", res_t); end
        n_checks++; if (res_sq !== '0) begin n_fail++; $display("FAIL reset_res_sq: got nonzero required 0"); end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b required 0000", err_flags); end
    endtask

    task automatic test_nominal;
        exp_w[0] = 32'h5;
        exp_w[1] = 32'h0;
        for (int i = 2; i < NW; i++)
            exp_w[i] = 32'hA5A5_0000 + i;
        n_acc = 0;
        pulse_start(EXPB);
        for (int i = 0; i < NW; i++) begin
            if (i == NW - 1) begin
                n_checks++;
                if (res_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_early_valid: got %b required 0", res_valid); end
            end
            send_beat(exp_w[i], 4'hF, 1'b0, 1'b0);
        end
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid_latency: got %b required 1", res_valid); end
        n_checks++; if (res_t !== 64'd5) begin n_fail++; $display("FAIL nominal_res_t: got %h required 5", res_t); end
        for (int k = 0; k < NW - 2; k++) begin
            n_checks++;
            if (res_sq[k*32 +: 32] !== 32'hA5A5_0000 + k + 2) begin
                n_fail++;
                $display("FAIL nominal_sq[%0d]: got %h required %h", k, res_sq[k*32 +: 32], 32'hA5A5_0000 + k + 2);
            end
        end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL nominal_err: got %b required 0000", err_flags); end
        n_checks++; if (n_acc != NW) begin n_fail++; $display("FAIL nominal_beats: got %0d required %0d", n_acc, NW); end
        handshake();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_release: got %b required 0", res_valid); end
        $display("nominal transfer: res_t=%h err=%b", res_t, err_flags);
    endtask

    task automatic test_backpressure;
        logic [63:0]   exp_t;
        logic [1023:0] exp_sq;
        fill_random($urandom, $urandom);
        exp_t = {exp_w[1], exp_w[0]};
        for (int k = 0; k < NW - 2; k++)
            exp_sq[k*32 +: 32] = exp_w[k+2];
        pulse_start(EXPB);
        send_all(1'b0);
        res_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                start_xfer = 1'b1;
                err_clr    = 1'b1;
            end
            tick();
            start_xfer = 1'b0;
            err_clr    = 1'b0;
            n_checks++;
            if (res_valid !== 1'b1 || res_t !== exp_t || res_sq !== exp_sq) begin
                n_fail++;
                $display("FAIL bp_stable cycle %0d: got valid=%b t=%h sq0=%h required valid=1 t=%h sq0=%h",
                         c, res_valid, res_t, res_sq[31:0], exp_t, exp_sq[31:0]);
            end
        end
        n_checks++; if (err_flags !== 4'b1000) begin n_fail++; $display("FAIL bp_err_ovr: got %b required 1000", err_flags); end
        handshake();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b required 0", res_valid); end
        tick();
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got tready=%b required 0", s_axis_tready); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL bp_err_clr: got %b required 0000", err_flags); end
        $display("backpressure: held 10 cycles, err after clear=%b", err_flags);
    endtask

    task automatic test_protocol_errors;
        int cyc;
        fill_random($urandom, $urandom);
        for (int i = 21; i < NW; i++)
            exp_w[i] = 32'h0;
        pulse_start(128);
        for (int i = 0; i <= 20; i++)
            send_beat(exp_w[i], (i == 4) ? 4'h7 : 4'hF, (i == 20), 1'b0);
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL proto_fill_tready: got %b required 0", s_axis_tready); end
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL proto_fill_cycles: got %0d required 13", cyc); end
        n_checks++; if (err_flags !== 4'b0111) begin n_fail++; $display("FAIL proto_err: got %b required 0111", err_flags); end
        n_checks++; if (res_t !== {exp_w[1], exp_w[0]}) begin n_fail++; $display("FAIL proto_res_t: got %h required %h", res_t, {exp_w[1], exp_w[0]}); end
        for (int k = 0; k < NW - 2; k++) begin
            n_checks++;
            if (res_sq[k*32 +: 32] !== exp_w[k+2]) begin
                n_fail++;
                $display("FAIL proto_word[%0d]: got %h required %h", k + 2, res_sq[k*32 +: 32], exp_w[k+2]);
            end
        end
        handshake();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL proto_err_clr: got %b required 0000", err_flags); end
        $display("protocol errors: fill cycles=%0d", cyc);
    endtask

    task automatic test_reset_mid;
        fill_random($urandom, $urandom);
        pulse_start(100);
        for (int i = 0; i <= 12; i++)
            send_beat(exp_w[i], 4'hF, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b required 0", res_valid); end
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tready: got %b required 0", s_axis_tready); end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_err: got %b required 0000", err_flags); end
        n_checks++; if (res_t !== 64'd0) begin n_fail++; $display("FAIL rst_mid_res_t: got %h required 0", res_t); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        fill_random($urandom, $urandom);
        pulse_start(EXPB);
        send_all(1'b0);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rst_new_valid: got %b required 1", res_valid); end
        n_checks++; if (res_t !== {exp_w[1], exp_w[0]}) begin n_fail++; $display("FAIL rst_new_res_t: got %h required %h", res_t, {exp_w[1], exp_w[0]}); end
        for (int k = 0; k < NW - 2; k++) begin
            n_checks++;
            if (res_sq[k*32 +: 32] !== exp_w[k+2]) begin
                n_fail++;
                $display("FAIL rst_new_word[%0d]: got %h required %h", k + 2, res_sq[k*32 +: 32], exp_w[k+2]);
            end
        end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL rst_new_err: got %b required 0000", err_flags); end
        handshake();
        $display("reset mid-collect: new res_t=%h", res_t);
    endtask

    task automatic test_stalls;
        fill_random($urandom, $urandom);
        n_acc = 0;
        pulse_start(EXPB);
        send_all(1'b1);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b required 1", res_valid); end
        n_checks++; if (n_acc != NW) begin n_fail++; $display("FAIL stall_beats: got %0d required %0d", n_acc, NW); end
        n_checks++; if (res_t !== {exp_w[1], exp_w[0]}) begin n_fail++; $display("FAIL stall_res_t: got %h required %h", res_t, {exp_w[1], exp_w[0]}); end
        for (int k = 0; k < NW - 2; k++) begin
            n_checks++;
            if (res_sq[k*32 +: 32] !== exp_w[k+2]) begin
                n_fail++;
                $display("FAIL stall_word[%0d]: got %h required %h", k + 2, res_sq[k*32 +: 32], exp_w[k+2]);
            end
        end
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL stall_err: got %b required 0000", err_flags); end
        handshake();
        $display("stalled transfer: beats=%0d", n_acc);
    endtask

`ifdef MSU_COLLECT_MONOTONIC_EN
    task automatic test_monotonic;
        fill_random(32'd9, 32'd0);
        pulse_start(EXPB);
        send_all(1'b0);
        handshake();
        n_checks++; if (err_flags[3] !== 1'b0) begin n_fail++; $display("FAIL mono_first: got %b required 0", err_flags[3]); end
        fill_random(32'd7, 32'd0);
        pulse_start(EXPB);
        send_all(1'b0);
        handshake();
        n_checks++; if (err_flags[3] !== 1'b1) begin n_fail++; $display("FAIL mono_second: got %b required 1", err_flags[3]); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL mono_clr: got %b required 0000", err_flags); end
        $display("monotonic: err after clear=%b", err_flags);
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        start_xfer    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        s_axis_xfer_size_in_bytes = '0;
        res_ready     = 1'b0;
        err_clr       = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_protocol_errors();
        test_reset_mid();
        test_stalls();
`ifdef MSU_COLLECT_MONOTONIC_EN
        test_monotonic();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
